dsp_chain_result_accum: RTL and testbench

Downstream consumer of the three-stage `int_sop_2` DSP chain. It takes the chain's 37-bit signed sum-of-products result stream and accumulates a programmable number of consecutive results into one wide saturating dot-product. Completed sums go into a 2-entry output FIFO with a valid/ready handshake. The DSP chain cannot stall, so the block never back-pressures its input; a completed sum that finds the FIFO full is dropped and flagged.

---
 rtl/dsp_chain_result_accum.sv | 214 +++++++++++++++++++++
 tb/tb_dsp_chain_result_accum.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_chain_result_accum.sv
// Purpose : accumulates a programmable number of consecutive signed DSP-chain
//           results into one wide saturating dot-product, queued in a 2-entry FIFO.
// Latency : out_valid_o rises 1 cycle after the completing beat when the FIFO is empty or emptying.
// Backpr. : never stalls the input; a completed sum that meets a full, non-popping FIFO is dropped and ovf_o set.
//
// Ports:
//   clk_i, reset_i     single rising-edge clock, synchronous active-high reset
//   in_valid_i         in_data_i carries a chain result this cycle
//   in_data_i          signed chain result (IN_W bits)
//   cfg_len_i          results per dot-product, 0 means 1; sampled on the first beat only
//   out_valid_o        FIFO head valid
//   out_ready_i        consumer takes the head this cycle
//   out_data_o         completed dot-product at the FIFO head (ACC_W bits, signed)
//   out_sat_o          the head sum was clamped at least once while accumulating
//   ovf_o              sticky: a completed sum was dropped because the FIFO was full
//   busy_o             a vector is partially accumulated

module dsp_chain_result_accum #(
  parameter int IN_W  = 37,
  parameter int ACC_W = 48,
  parameter int LEN_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             in_valid_i,
  input  logic [IN_W-1:0]  in_data_i,
  input  logic [LEN_W-1:0] cfg_len_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [ACC_W-1:0] out_data_o,
  output logic             out_sat_o,
  output logic             ovf_o,
  output logic             busy_o
);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Accumulator state
  // ---------------------------------------------------------------------------
  state_t             state_q;
  logic               busy_q;
  logic [ACC_W-1:0]   acc_q,  acc_d;
  logic [LEN_W-1:0]   cnt_q,  cnt_d;
  logic [LEN_W-1:0]   len_q,  len_d;
  logic               sat_q,  sat_d;

  logic [LEN_W-1:0]   len_eff;
  logic [LEN_W-1:0]   cnt_inc;
  logic [ACC_W-1:0]   in_sext;
  logic [ACC_W:0]     sum_wide;
  logic               clamp_hi;
  logic               clamp_lo;
  logic [ACC_W-1:0]   sat_sum;

  // Completion of a vector on this cycle's beat
  logic               done_vld;
  logic [ACC_W-1:0]   done_dat;
  logic               done_sat;

  assign len_eff = (cfg_len_i == '0) ? LEN_W'(1) : cfg_len_i;
  assign cnt_inc = cnt_q + LEN_W'(1);
  assign in_sext = ACC_W'($signed(in_data_i));

  // One extra bit of headroom: the two top bits disagree exactly when the
  // ACC_W-bit signed result would have wrapped.
  assign sum_wide = {acc_q[ACC_W-1], acc_q} + {in_sext[ACC_W-1], in_sext};
  assign clamp_hi = ~sum_wide[ACC_W] &  sum_wide[ACC_W-1];
  assign clamp_lo =  sum_wide[ACC_W] & ~sum_wide[ACC_W-1];
  assign sat_sum  = clamp_hi ? ACC_MAX :
                    clamp_lo ? ACC_MIN : sum_wide[ACC_W-1:0];

  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    sat_d    = sat_q;
    done_vld = 1'b0;
    done_dat = acc_q;
    done_sat = 1'b0;
    if (in_valid_i) begin
      if (state_q == S_IDLE) begin
        // First beat restarts the vector; a length-1 vector completes here.
        acc_d    = in_sext;
        cnt_d    = LEN_W'(1);
        len_d    = len_eff;
        sat_d    = 1'b0;
        done_vld = (len_eff == LEN_W'(1));
        done_dat = in_sext;
        done_sat = 1'b0;
      end else begin
        acc_d    = sat_sum;
        cnt_d    = cnt_inc;
        sat_d    = sat_q | clamp_hi | clamp_lo;
        done_vld = (cnt_inc == len_q);
        done_dat = sat_sum;
        done_sat = sat_q | clamp_hi | clamp_lo;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      sat_q <= sat_d;
      case (state_q)
        S_IDLE: begin
          if (in_valid_i && (len_eff != LEN_W'(1))) begin
            state_q <= S_ACCUM;
            busy_q  <= 1'b1;
          end
        end
        S_ACCUM: begin
          if (done_vld) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // 2-entry output FIFO: a registered head slot feeding the outputs directly,
  // plus one tail slot behind it.
  // ---------------------------------------------------------------------------
  logic               head_vld_q;
  logic [ACC_W-1:0]   head_dat_q;
  logic               head_sat_q;
  logic               tail_vld_q;
  logic [ACC_W-1:0]   tail_dat_q;
  logic               tail_sat_q;
  logic               ovf_q;

  logic               pop;
  logic               full;
  logic               push_ok;
  logic               drop;

  assign pop     = head_vld_q & out_ready_i;
  assign full    = head_vld_q & tail_vld_q;
  // A full FIFO still accepts the push when the head leaves on the same edge.
  assign push_ok = done_vld & (~full | pop);
  assign drop    = done_vld & full & ~pop;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_vld_q <= 1'b0;
      head_dat_q <= '0;
      head_sat_q <= 1'b0;
      tail_vld_q <= 1'b0;
      tail_dat_q <= '0;
      tail_sat_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (drop) begin
        ovf_q <= 1'b1;
      end
      if (pop) begin
        if (tail_vld_q) begin
          // Tail advances to head; a new push refills the tail.
          head_dat_q <= tail_dat_q;
          head_sat_q <= tail_sat_q;
          tail_vld_q <= push_ok;
          if (push_ok) begin
            tail_dat_q <= done_dat;
            tail_sat_q <= done_sat;
          end
        end else if (push_ok) begin
          head_dat_q <= done_dat;
          head_sat_q <= done_sat;
        end else begin
          head_vld_q <= 1'b0;
        end
      end else if (push_ok) begin
        if (!head_vld_q) begin
          head_vld_q <= 1'b1;
          head_dat_q <= done_dat;
          head_sat_q <= done_sat;
        end else begin
          tail_vld_q <= 1'b1;
          tail_dat_q <= done_dat;
          tail_sat_q <= done_sat;
        end
      end
    end
  end

  assign out_valid_o = head_vld_q;
  assign out_data_o  = head_dat_q;
  assign out_sat_o   = head_sat_q;
  assign ovf_o       = ovf_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_dsp_chain_result_accum.sv
// Purpose : directed bench for dsp_chain_result_accum with a queue scoreboard.
// Latency : inputs driven 1 time unit after the rising edge; outputs sampled there or on the falling edge.
// Backpr. : out_ready is driven per step to exercise full, drop and same-cycle pop cases.

module tb_dsp_chain_result_accum;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [36:0] in_data;
  logic [7:0]  cfg_len;
  logic        out_ready;
  logic        sat_en;

  logic        o_valid;
  logic [47:0] o_data;
  logic        o_sat;
  logic        o_ovf;
  logic        o_busy;

  logic        s_valid;
  logic [39:0] s_data;
  logic        s_sat;
  logic        s_ovf;
  logic        s_busy;

  int tests = 0;
  int fails = 0;

  logic [48:0] q0[$];
  logic [40:0] q1[$];
  logic [48:0] e0;
  logic [40:0] e1;

  dsp_chain_result_accum u_dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .in_valid_i (in_valid),
    .in_data_i  (in_data),
    .cfg_len_i  (cfg_len),
    .out_valid_o(o_valid),
    .out_ready_i(out_ready),
    .out_data_o (o_data),
    .out_sat_o  (o_sat),
    .ovf_o      (o_ovf),
    .busy_o     (o_busy)
  );

  dsp_chain_result_accum #(.IN_W(37), .ACC_W(40), .LEN_W(8)) u_sat (
    .clk_i      (clk),
    .reset_i    (reset),
    .in_valid_i (in_valid & sat_en),
    .in_data_i  (in_data),
    .cfg_len_i  (cfg_len),
    .out_valid_o(s_valid),
    .out_ready_i(out_ready),
    .out_data_o (s_data),
    .out_sat_o  (s_sat),
    .ovf_o      (s_ovf),
    .busy_o     (s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push0(input longint v, input bit s);
    q0.push_back({s, v[47:0]});
  endfunction

  function automatic void push1(input longint v, input bit s);
    q1.push_back({s, v[39:0]});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input longint v);
    in_valid = 1'b1;
    in_data  = v[36:0];
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) tick();
    chk({tag, "_q0_left"}, 64'(q0.size()), 64'd0);
    chk({tag, "_q1_left"}, 64'(q1.size()), 64'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, 64'(o_valid), 64'd0);
    chk({tag, "_data"},  64'(o_data),  64'd0);
    chk({tag, "_sat"},   64'(o_sat),   64'd0);
    chk({tag, "_ovf"},   64'(o_ovf),   64'd0);
    chk({tag, "_busy"},  64'(o_busy),  64'd0);
  endtask

  // Scoreboard: every accepted handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && o_valid && out_ready) begin
      if (q0.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL unexpected_out observed=%0h expected=none", o_data);
      end else begin
        e0 = q0.pop_front();
        chk("dot_data", 64'(o_data), 64'(e0[47:0]));
        chk("dot_sat",  64'(o_sat),  64'(e0[48]));
      end
    end
    if (!reset && s_valid && out_ready) begin
      if (q1.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL unexpected_sat_out observed=%0h expected=none", s_data);
      end else begin
        e1 = q1.pop_front();
        chk("sat_data", 64'(s_data), 64'(e1[39:0]));
        chk("sat_sat",  64'(s_sat),  64'(e1[40]));
      end
    end
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    cfg_len   = 8'd1;
    out_ready = 1'b0;
    sat_en    = 1'b0;
    tick();
    tick();
    chk_reset_state("rst");
    reset = 1'b0;

    // Basic 3-beat sum: 5 - 2 + 10 = 13
    out_ready = 1'b1;
    cfg_len   = 8'd3;
    push0(13, 1'b0);
    beat(5);
    chk("basic_busy1", 64'(o_busy), 64'd1);
    chk("basic_val1",  64'(o_valid), 64'd0);
    beat(-2);
    chk("basic_busy2", 64'(o_busy), 64'd1);
    chk("basic_val2",  64'(o_valid), 64'd0);
    beat(10);
    chk("basic_busy3", 64'(o_busy), 64'd0);
    chk("basic_val3",  64'(o_valid), 64'd1);
    idle();
    chk("basic_val4",  64'(o_valid), 64'd0);

    // Length 0 behaves as 1, with a gap between beats
    cfg_len = 8'd0;
    push0(7, 1'b0);
    push0(-9, 1'b0);
    beat(7);
    chk("len0_val_a", 64'(o_valid), 64'd1);
    chk("len0_busy",  64'(o_busy),  64'd0);
    idle();
    idle();
    chk("len0_gap",   64'(o_valid), 64'd0);
    beat(-9);
    chk("len0_val_b", 64'(o_valid), 64'd1);
    idle();

    // Saturation on the 40-bit instance; the 48-bit one has headroom
    sat_en  = 1'b1;
    cfg_len = 8'd16;
    push0(64'h0000_00FF_FFFF_FFF0, 1'b0);
    push1(64'h0000_007F_FFFF_FFFF, 1'b1);
    for (int i = 0; i < 16; i++) beat(64'h0000_000F_FFFF_FFFF);
    chk("satp_val",  64'(s_valid), 64'd1);
    chk("satp_main", 64'(o_valid), 64'd1);
    push0(-64'sh0000_0100_0000_0000, 1'b0);
    push1(-64'sh0000_0080_0000_0000, 1'b1);
    for (int i = 0; i < 16; i++) beat(-64'sh0000_0010_0000_0000);
    chk("satn_val",  64'(s_valid), 64'd1);
    sat_en = 1'b0;
    idle();
    drain("sat");

    // Length 1 at full rate
    cfg_len = 8'd1;
    for (int i = 0; i < 4; i++) begin
      push0(longint'(i * 3 + 1), 1'b0);
      beat(longint'(i * 3 + 1));
      chk("stream_val", 64'(o_valid), 64'd1);
    end
    idle();
    chk("stream_end", 64'(o_valid), 64'd0);
    chk("stream_ovf", 64'(o_ovf),   64'd0);

    // Overflow: third result dropped while nobody pops
    out_ready = 1'b0;
    push0(1, 1'b0);
    push0(2, 1'b0);
    beat(1);
    beat(2);
    chk("ovf_before", 64'(o_ovf), 64'd0);
    beat(3);
    chk("ovf_set",    64'(o_ovf), 64'd1);
    idle();
    chk("ovf_hold_val", 64'(o_valid), 64'd1);
    chk("ovf_hold_dat", 64'(o_data),  64'd1);
    out_ready = 1'b1;
    drain("ovf");
    tick();
    chk("ovf_empty",  64'(o_valid), 64'd0);
    chk("ovf_sticky", 64'(o_ovf),   64'd1);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("ovf_cleared", 64'(o_ovf), 64'd0);

    // Full FIFO with a same-cycle pop accepts the new result
    out_ready = 1'b0;
    push0(1, 1'b0);
    push0(2, 1'b0);
    push0(3, 1'b0);
    beat(1);
    beat(2);
    out_ready = 1'b1;
    beat(3);
    chk("fullpop_ovf", 64'(o_ovf), 64'd0);
    idle();
    idle();
    idle();
    chk("fullpop_empty", 64'(o_valid), 64'd0);
    chk("fullpop_ovf2",  64'(o_ovf),   64'd0);
    drain("fullpop");

    // Reset mid-vector discards the partial sum
    cfg_len = 8'd4;
    beat(100);
    beat(200);
    chk("midrst_busy", 64'(o_busy), 64'd1);
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_state("midrst");
    cfg_len = 8'd2;
    push0(2, 1'b0);
    beat(1);
    chk("midrst_val1", 64'(o_valid), 64'd0);
    beat(1);
    chk("midrst_val2", 64'(o_valid), 64'd1);
    chk("midrst_dat",  64'(o_data),  64'd2);
    idle();
    drain("end");
    chk("end_sat_ovf",  64'(s_ovf),  64'd0);
    chk("end_sat_busy", 64'(s_busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
